shared_ram_rr: RTL

- N-port shared data memory for the multicore processor. Each core gets its own request channel.
- A round-robin arbiter grants one access per cycle to a single-port RAM array with registered read.
- Generalises the single-port RAM with three additions: port count, fair arbitration, and per-port read-valid signalling.
- Sits between the N core datapaths and the common data memory.

---
 rtl/shared_ram_rr_if.sv | 25 ++
 rtl/shared_ram_rr.sv | 86 ++++++++
 2 files changed

// File: rtl/shared_ram_rr_if.sv
// Bundles the per-core request channels and the shared grant/read-return signals of shared_ram_rr.
// The master side drives the requests. The slave side (the RAM arbiter) returns the grant and the read data.
interface shared_ram_rr_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8,
    parameter int N_PORTS    = 4
);
    logic [N_PORTS-1:0]            req;
    logic [N_PORTS-1:0]            wrEn;
    logic [N_PORTS*ADDR_WIDTH-1:0] address;
    logic [N_PORTS*DATA_WIDTH-1:0] dataIn;
    logic [N_PORTS-1:0]            gnt;
    logic [N_PORTS-1:0]            rdValid;
    logic [DATA_WIDTH-1:0]         dataOut;

    modport master (
        output req, wrEn, address, dataIn,
        input  gnt, rdValid, dataOut
    );

    modport slave (
        input  req, wrEn, address, dataIn,
        output gnt, rdValid, dataOut
    );
endinterface

// File: rtl/shared_ram_rr.sv
// N-port round-robin front end for a single-port RAM. The grant is combinational. Read data and rdValid appear one cycle after the grant edge.
// Backpressure: an ungranted core holds req and its request fields until it sees gnt. The grant returns within N_PORTS-1 cycles.
module shared_ram_rr #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int N_PORTS    = 4
) (
    input  logic          clk,
    input  logic          rst,
    shared_ram_rr_if.slave bus
);
    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic [PTR_W:0]        w_sum;
    logic                  w_any;
    logic                  w_hit;
    logic                  w_wr;
    logic [N_PORTS-1:0]    w_gnt;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdat;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dout;
    logic [N_PORTS-1:0]    r_rdv;

    // Scan the ports starting at r_ptr and wrapping. The first requester found wins.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(N_PORTS)) begin
                w_sum = w_sum - (PTR_W+1)'(N_PORTS);
            end
            if (!w_any && bus.req[w_sum[PTR_W-1:0]]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_sum[PTR_W-1:0];
            end
        end
    end

    // Gating with rst keeps gnt low and blocks writes while reset is held.
    assign w_hit = w_any & ~rst;

    always_comb begin
        w_gnt = '0;
        if (w_hit) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign w_addr = bus.address[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdat = bus.dataIn[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_wr   = w_hit & bus.wrEn[w_gnt_idx];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_addr] <= w_wdat;
        end
    end

    // dataOut captures the addressed word on every grant (read-first on writes). Only reads raise rdValid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_rdv  <= '0;
            r_dout <= '0;
        end else begin
            r_rdv <= '0;
            if (w_hit) begin
                r_dout <= r_mem[w_addr];
                if (!bus.wrEn[w_gnt_idx]) begin
                    r_rdv <= w_gnt;
                end
                r_ptr <= (w_gnt_idx == PTR_W'(N_PORTS-1)) ? '0 : w_gnt_idx + PTR_W'(1);
            end
        end
    end

    assign bus.gnt     = w_gnt;
    assign bus.rdValid = r_rdv;
    assign bus.dataOut = r_dout;
endmodule
